player_life_ctrl: RTL and testbench

- Sequences the player's life cycle for the Bomber-Man player and drives the lives counter's control strobes: `player_hit`, `powerUp_inc` and `lives_reset`.
- Converts raw level collision inputs into single-cycle strobes and arbitrates simultaneous hit and power-up events.
- Runs the death, respawn and invulnerability timing, counted in video frames.
- Sits between the collision/game-logic block and the lives counter; its outputs also feed the player drawing and position logic.

---
 rtl/player_life_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_player_life_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_life_ctrl.sv
// Player life-cycle sequencer: edge-detects collision inputs, arbitrates hit/power-up strobes to the
// lives counter, and times death, respawn and invulnerability in frames. Optional PLAYER_GOD_MODE_EN.
module player_life_ctrl #(
    parameter int INVULN_FRAMES = 90,
    parameter int DEATH_FRAMES  = 60,
    parameter int BLINK_FRAMES  = 8,
    parameter int MAX_LIVES     = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       hit_explosion,
    input  logic       hit_enemy,
    input  logic       powerup_collected,
    input  logic       game_restart,
`ifdef PLAYER_GOD_MODE_EN
    input  logic       sw_god,
`endif
    input  logic [3:0] lives,
    output logic       player_hit,
    output logic       powerUp_inc,
    output logic       lives_reset,
    output logic       respawn,
    output logic       invulnerable,
    output logic       player_visible,
    output logic       game_over,
    output logic [2:0] ctrl_state
);

    // state     | meaning
    // ALIVE     | normal play, hits and power-ups accepted
    // DYING     | death animation, DEATH_FRAMES frames
    // RESPAWN   | one cycle, reload start position
    // INVULN    | blinking, hits ignored, INVULN_FRAMES frames
    // GAME_OVER | no lives left, waits for restart
    typedef enum logic [2:0] {
        S_ALIVE     = 3'd0,
        S_DYING     = 3'd1,
        S_RESPAWN   = 3'd2,
        S_INVULN    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int CNT_MAX   = (INVULN_FRAMES > DEATH_FRAMES) ? INVULN_FRAMES : DEATH_FRAMES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BLINK_BIT = $clog2(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [3:0]       LIVES_CAP   = 4'(MAX_LIVES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             cnt_clr, cnt_inc;
    logic             last_life;
    logic             pu_pending, pu_pending_nxt;
    logic             hit_prev, pu_prev, rst_prev;
    logic             hit_req, pu_req, rst_req;
    logic             hit_lvl;
    logic             god;
    logic             pu_window, pu_want;

    assign hit_lvl = hit_explosion | hit_enemy;

`ifdef PLAYER_GOD_MODE_EN
    assign god = sw_god;
`else
    assign god = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_prev <= 1'b0;
            pu_prev  <= 1'b0;
            rst_prev <= 1'b0;
            hit_req  <= 1'b0;
            pu_req   <= 1'b0;
            rst_req  <= 1'b0;
        end else begin
            hit_prev <= hit_lvl;
            pu_prev  <= powerup_collected;
            rst_prev <= game_restart;
            hit_req  <= hit_lvl & ~hit_prev;
            pu_req   <= powerup_collected & ~pu_prev;
            rst_req  <= game_restart & ~rst_prev;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_ALIVE;
            count      <= '0;
            last_life  <= 1'b0;
            pu_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            pu_pending <= pu_pending_nxt;
            if (player_hit)
                last_life <= (lives <= 4'd1);
            // Saturating frame counter: never wraps back into a blink or timeout window.
            if (cnt_clr)
                count <= '0;
            else if (cnt_inc && (count != {CNT_W{1'b1}}))
                count <= count + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        player_hit     = 1'b0;
        powerUp_inc    = 1'b0;
        lives_reset    = 1'b0;
        respawn        = 1'b0;
        invulnerable   = 1'b0;
        player_visible = 1'b1;
        game_over      = 1'b0;
        pu_window      = 1'b0;
        pu_want        = 1'b0;
        pu_pending_nxt = pu_pending;

        case (state)
            S_ALIVE: begin
                pu_window = 1'b1;
                if (hit_req && !god) begin
                    player_hit = 1'b1;
                    state_nxt  = S_DYING;
                    cnt_clr    = 1'b1;
                end
            end
            S_DYING: begin
                cnt_inc = startOfFrame;
                if (startOfFrame && (count == DEATH_LAST))
                    state_nxt = last_life ? S_GAME_OVER : S_RESPAWN;
            end
            S_RESPAWN: begin
                pu_window    = 1'b1;
                respawn      = 1'b1;
                invulnerable = 1'b1;
                state_nxt    = S_INVULN;
                cnt_clr      = 1'b1;
            end
            S_INVULN: begin
                pu_window      = 1'b1;
                invulnerable   = 1'b1;
                cnt_inc        = startOfFrame;
                player_visible = ~count[BLINK_BIT];
                if (startOfFrame && (count == INVULN_LAST))
                    state_nxt = S_ALIVE;
            end
            S_GAME_OVER: begin
                game_over      = 1'b1;
                player_visible = 1'b0;
                if (rst_req) begin
                    lives_reset = 1'b1;
                    state_nxt   = S_RESPAWN;
                end
            end
            default: state_nxt = S_ALIVE;
        endcase

`ifdef PLAYER_GOD_MODE_EN
        if (state != S_GAME_OVER)
            invulnerable = 1'b1;
`endif

        // A power-up colliding with a hit waits in pu_pending; a dead player forfeits it.
        pu_want = pu_window & (pu_req | pu_pending);
        if (pu_want && !player_hit && (lives < LIVES_CAP))
            powerUp_inc = 1'b1;

        if (!pu_window || (state_nxt == S_DYING))
            pu_pending_nxt = 1'b0;
        else if (pu_want)
            pu_pending_nxt = player_hit;
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Self-checking bench for player_life_ctrl with short frame parameters: table-driven
// ALIVE/power-up vectors plus hand-written death, game-over, arbitration and reset sequences.
module tb_player_life_ctrl;

    localparam int DF = 4;
    localparam int IF_ = 8;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0;
    logic       hit_explosion = 1'b0;
    logic       hit_enemy = 1'b0;
    logic       powerup_collected = 1'b0;
    logic       game_restart = 1'b0;
    logic [3:0] lives = 4'd3;
`ifdef PLAYER_GOD_MODE_EN
    logic       sw_god = 1'b0;
`endif
    logic       player_hit, powerUp_inc, lives_reset, respawn;
    logic       invulnerable, player_visible, game_over;
    logic [2:0] ctrl_state;

    player_life_ctrl #(
        .INVULN_FRAMES(IF_),
        .DEATH_FRAMES (DF),
        .BLINK_FRAMES (BF),
        .MAX_LIVES    (3)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (sof),
        .hit_explosion    (hit_explosion),
        .hit_enemy        (hit_enemy),
        .powerup_collected(powerup_collected),
        .game_restart     (game_restart),
`ifdef PLAYER_GOD_MODE_EN
        .sw_god           (sw_god),
`endif
        .lives            (lives),
        .player_hit       (player_hit),
        .powerUp_inc      (powerUp_inc),
        .lives_reset      (lives_reset),
        .respawn          (respawn),
        .invulnerable     (invulnerable),
        .player_visible   (player_visible),
        .game_over        (game_over),
        .ctrl_state       (ctrl_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_ph = 0, n_pi = 0, n_lr = 0, n_rs = 0, n_overlap = 0;
    int b_ph, b_pi, b_lr, b_rs;

    // Pulse counters sample 2 time units after each falling edge, so a read at a falling edge
    // sees every earlier cycle and never races the current one.
    always @(negedge clk) begin
        #2;
        if (resetN) begin
            n_ph += int'(player_hit);
            n_pi += int'(powerUp_inc);
            n_lr += int'(lives_reset);
            n_rs += int'(respawn);
            if (int'(player_hit) + int'(powerUp_inc) + int'(lives_reset) > 1)
                n_overlap++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            frame();
            tick(2);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " state"}, ctrl_state, 0);
        chk({tag, " player_hit"}, player_hit, 0);
        chk({tag, " powerUp_inc"}, powerUp_inc, 0);
        chk({tag, " lives_reset"}, lives_reset, 0);
        chk({tag, " respawn"}, respawn, 0);
        chk({tag, " invulnerable"}, invulnerable, 0);
        chk({tag, " visible"}, player_visible, 1);
        chk({tag, " game_over"}, game_over, 0);
    endtask

    typedef struct {
        logic       he, pu, rs;
        logic [3:0] lv;
        logic       e_ph, e_pi, e_lr, e_inv, e_vis, e_go;
        logic [2:0] e_st;
    } vec_t;

    vec_t tbl[10];

    initial begin
        //            he   pu   rs   lv     ph   pi   lr   inv  vis  go   st
        tbl[0] = '{1'b0,1'b0,1'b0,4'd3, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[1] = '{1'b0,1'b1,1'b0,4'd3, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[2] = '{1'b0,1'b1,1'b0,4'd3, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[3] = '{1'b0,1'b0,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[4] = '{1'b0,1'b1,1'b0,4'd2, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[5] = '{1'b0,1'b1,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[6] = '{1'b0,1'b0,1'b1,4'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[7] = '{1'b0,1'b0,1'b1,4'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[8] = '{1'b0,1'b1,1'b0,4'd1, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,3'd0};
        tbl[9] = '{1'b0,1'b0,1'b0,4'd3, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0};

        tick(2);
        chk_reset_outputs("reset");
        resetN = 1'b1;
        tick(1);

        for (int i = 0; i < 10; i++) begin
            hit_enemy         = tbl[i].he;
            powerup_collected = tbl[i].pu;
            game_restart      = tbl[i].rs;
            lives             = tbl[i].lv;
            tick(1);
            chk($sformatf("vec%0d player_hit", i), player_hit, tbl[i].e_ph);
            chk($sformatf("vec%0d powerUp_inc", i), powerUp_inc, tbl[i].e_pi);
            chk($sformatf("vec%0d lives_reset", i), lives_reset, tbl[i].e_lr);
            chk($sformatf("vec%0d invulnerable", i), invulnerable, tbl[i].e_inv);
            chk($sformatf("vec%0d visible", i), player_visible, tbl[i].e_vis);
            chk($sformatf("vec%0d game_over", i), game_over, tbl[i].e_go);
            chk($sformatf("vec%0d state", i), ctrl_state, tbl[i].e_st);
        end
        powerup_collected = 1'b0;
        tick(2);

        // Held hit with lives=3: one strobe, death, respawn, blinking invulnerability.
        lives = 4'd3;
        b_ph = n_ph; b_rs = n_rs;
        hit_enemy = 1'b1;
        tick(1);
        chk("hit strobe latency", player_hit, 1);
        tick(49);
        hit_enemy = 1'b0;
        chk("dying after hit", ctrl_state, 1);
        lives = 4'd2;
        powerup_collected = 1'b1;
        tick(1);
        chk("pu dropped in dying", powerUp_inc, 0);
        powerup_collected = 1'b0;
        lives = 4'd3;
        tick(1);
        chk("single hit pulse", n_ph - b_ph, 1);
        for (int k = 1; k <= DF; k++) begin
            frame();
            if (k < DF) begin
                chk($sformatf("dying frame %0d state", k), ctrl_state, 1);
                chk($sformatf("dying frame %0d visible", k), player_visible, 1);
                tick(2);
            end else begin
                chk("respawn state", ctrl_state, 2);
                chk("respawn pulse", respawn, 1);
                chk("respawn invulnerable", invulnerable, 1);
            end
        end
        tick(1);
        chk("invuln entry state", ctrl_state, 3);
        chk("invuln entry respawn low", respawn, 0);
        chk("invuln entry visible", player_visible, 1);
        tick(2);
        for (int k = 1; k <= IF_; k++) begin
            frame();
            if (k < IF_) begin
                chk($sformatf("invuln frame %0d state", k), ctrl_state, 3);
                chk($sformatf("invuln frame %0d invulnerable", k), invulnerable, 1);
                chk($sformatf("invuln frame %0d visible", k), player_visible, ((k / BF) % 2) == 0);
            end else begin
                chk("alive after invuln", ctrl_state, 0);
                chk("alive invulnerable low", invulnerable, 0);
                chk("alive visible", player_visible, 1);
            end
            if (k == 3) begin
                hit_explosion = 1'b1;
                tick(1);
                chk("hit ignored in invuln", player_hit, 0);
            end
            if (k == 5) hit_explosion = 1'b0;
            tick(2);
        end
        chk("hit count after invuln", n_ph - b_ph, 1);
        chk("respawn count", n_rs - b_rs, 1);

        // Coincident hit and power-up: only the hit goes out, power-up is lost in DYING.
        lives = 4'd2;
        b_pi = n_pi;
        hit_enemy = 1'b1;
        powerup_collected = 1'b1;
        tick(1);
        chk("coincide player_hit", player_hit, 1);
        chk("coincide powerUp_inc", powerUp_inc, 0);
        tick(1);
        chk("coincide dying", ctrl_state, 1);
        chk("coincide pu later", powerUp_inc, 0);
        hit_enemy = 1'b0;
        powerup_collected = 1'b0;
        run_frames(DF);
        run_frames(IF_);
        chk("coincide back alive", ctrl_state, 0);
        chk("coincide no pu at all", n_pi - b_pi, 0);

        // Last life: game over, ignored events, restart sequence.
        lives = 4'd1;
        b_lr = n_lr; b_rs = n_rs; b_pi = n_pi;
        hit_enemy = 1'b1;
        tick(1);
        chk("last life hit", player_hit, 1);
        hit_enemy = 1'b0;
        tick(1);
        run_frames(DF);
        chk("game over state", ctrl_state, 4);
        chk("game over flag", game_over, 1);
        chk("game over visible", player_visible, 0);
        chk("game over invulnerable", invulnerable, 0);
        lives = 4'd2;
        hit_enemy = 1'b1;
        powerup_collected = 1'b1;
        tick(1);
        chk("hit ignored in game over", player_hit, 0);
        chk("pu ignored in game over", powerUp_inc, 0);
        hit_enemy = 1'b0;
        powerup_collected = 1'b0;
        tick(1);
        game_restart = 1'b1;
        tick(1);
        chk("restart lives_reset", lives_reset, 1);
        chk("restart still game over", ctrl_state, 4);
        tick(1);
        chk("restart respawn state", ctrl_state, 2);
        chk("restart respawn pulse", respawn, 1);
        chk("restart lives_reset low", lives_reset, 0);
        tick(1);
        chk("restart invuln", ctrl_state, 3);
        game_restart = 1'b0;
        tick(1);
        run_frames(IF_);
        chk("restart back alive", ctrl_state, 0);
        chk("lives_reset count", n_lr - b_lr, 1);
        chk("restart respawn count", n_rs - b_rs, 1);
        chk("game over pu count", n_pi - b_pi, 0);

        // Reset in the middle of DYING.
        lives = 4'd3;
        b_lr = n_lr;
        hit_enemy = 1'b1;
        tick(1);
        hit_enemy = 1'b0;
        tick(1);
        frame();
        tick(2);
        chk("pre-reset dying", ctrl_state, 1);
        resetN = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick(2);
        resetN = 1'b1;
        tick(3);
        chk("post reset alive", ctrl_state, 0);
        chk("reset no lives_reset", n_lr - b_lr, 0);
        hit_enemy = 1'b1;
        tick(1);
        chk("post reset hit", player_hit, 1);
        tick(1);
        chk("post reset dying", ctrl_state, 1);
        hit_enemy = 1'b0;
        tick(2);
        chk("strobe overlap", n_overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
